// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control unit for the 5-stage RV32I pipeline.
// Decodes in ID, resolves branches in EX, owns forwarding, stall and flush.
module pipe_ctrl #(
    parameter int ENABLE_FWD = 1,
    parameter int REG_AW     = 5,
    parameter int ALUCTRL_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           id_op,
    input  logic [2:0]           id_funct3,
    input  logic                 id_funct7_5,
    input  logic [REG_AW-1:0]    id_rs1,
    input  logic [REG_AW-1:0]    id_rs2,
    input  logic [REG_AW-1:0]    id_rd,
    input  logic                 ex_zero,
    input  logic                 ex_lt,
    input  logic                 ex_ltu,
    output logic [2:0]           d_imm_src,
    output logic [ALUCTRL_W-1:0] e_alu_control,
    output logic                 e_alu_src,
    output logic [1:0]           e_fwd_a,
    output logic [1:0]           e_fwd_b,
    output logic [1:0]           e_pcsrc,
    output logic                 e_illegal,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 m_mem_write,
    output logic [REG_AW-1:0]    m_rd,
    output logic                 w_reg_write,
    output logic [1:0]           w_result_src,
    output logic [REG_AW-1:0]    w_rd
);
    typedef logic [ALUCTRL_W-1:0] aluc_t;
    typedef logic [REG_AW-1:0]    reg_t;

    localparam aluc_t A_ADD   = aluc_t'(0);
    localparam aluc_t A_SUB   = aluc_t'(1);
    localparam aluc_t A_AND   = aluc_t'(2);
    localparam aluc_t A_OR    = aluc_t'(3);
    localparam aluc_t A_XOR   = aluc_t'(4);
    localparam aluc_t A_SLT   = aluc_t'(5);
    localparam aluc_t A_SLTU  = aluc_t'(6);
    localparam aluc_t A_SLL   = aluc_t'(7);
    localparam aluc_t A_SRL   = aluc_t'(8);
    localparam aluc_t A_SRA   = aluc_t'(9);
    localparam aluc_t A_PASSB = aluc_t'(10);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       load;
        logic       illegal;
        logic       alu_src;
        aluc_t      alu_ctrl;
        logic [2:0] funct3;
        reg_t       rs1;
        reg_t       rs2;
        reg_t       rd;
    } id_ex_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        reg_t       rd;
    } ex_mem_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        reg_t       rd;
    } mem_wb_t;

    id_ex_t  dec, ex_d, ex_q;
    ex_mem_t mem_d, mem_q;
    mem_wb_t wb_d, wb_q;
    logic    taken, hazard, redirect;

    function automatic aluc_t alu_op(input logic [2:0] f3, input logic alt,
                                     input logic is_r);
        case (f3)
            3'b000:  alu_op = (alt && is_r) ? A_SUB : A_ADD;
            3'b001:  alu_op = A_SLL;
            3'b010:  alu_op = A_SLT;
            3'b011:  alu_op = A_SLTU;
            3'b100:  alu_op = A_XOR;
            3'b101:  alu_op = alt ? A_SRA : A_SRL;
            3'b110:  alu_op = A_OR;
            default: alu_op = A_AND;
        endcase
    endfunction

    function automatic logic rd_hit(input logic wr, input reg_t rd,
                                    input reg_t rs1, input reg_t rs2);
        return wr && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

    function automatic logic [1:0] fwd_sel(input reg_t rs,
                                           input logic m_wr, input reg_t m_d,
                                           input logic w_wr, input reg_t w_d);
        if (m_wr && (m_d != '0) && (m_d == rs)) return 2'b10;
        if (w_wr && (w_d != '0) && (w_d == rs)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        dec        = '0;
        dec.funct3 = id_funct3;
        dec.rs1    = id_rs1;
        dec.rs2    = id_rs2;
        d_imm_src  = 3'b000;
        unique case (id_op)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.rd        = id_rd;
                dec.alu_ctrl  = alu_op(id_funct3, id_funct7_5, 1'b1);
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.rd        = id_rd;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_op(id_funct3, id_funct7_5, 1'b0);
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.rd         = id_rd;
                dec.alu_src    = 1'b1;
                dec.load       = 1'b1;
                dec.result_src = 2'b01;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                d_imm_src     = 3'b001;
            end
            OP_BR: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = A_SUB;
                d_imm_src    = 3'b010;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.rd         = id_rd;
                dec.jal        = 1'b1;
                dec.result_src = 2'b10;
                d_imm_src      = 3'b011;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.rd         = id_rd;
                dec.jalr       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.rd        = id_rd;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = (id_op == OP_LUI) ? A_PASSB : A_ADD;
                d_imm_src     = 3'b100;
            end
            default: begin
                dec.rs1     = '0;
                dec.rs2     = '0;
                dec.illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        case (ex_q.funct3)
            3'b000:  taken = ex_zero;
            3'b001:  taken = !ex_zero;
            3'b100:  taken = ex_lt;
            3'b101:  taken = !ex_lt;
            3'b110:  taken = ex_ltu;
            3'b111:  taken = !ex_ltu;
            default: taken = 1'b0;
        endcase
    end

    assign e_pcsrc = ex_q.jalr ? 2'b10 :
                     (ex_q.jal || (ex_q.branch && taken)) ? 2'b01 : 2'b00;
    assign redirect = (e_pcsrc != 2'b00);

    // Without forwarding every writer still in EX or MEM blocks the reader.
    assign hazard = (ENABLE_FWD != 0)
        ? (ex_q.load && rd_hit(ex_q.reg_write, ex_q.rd, id_rs1, id_rs2))
        : (rd_hit(ex_q.reg_write, ex_q.rd, id_rs1, id_rs2) ||
           rd_hit(mem_q.reg_write, mem_q.rd, id_rs1, id_rs2));

    assign stall_f = hazard && !redirect;
    assign stall_d = hazard && !redirect;
    assign flush_d = redirect;
    assign flush_e = redirect || hazard;

    assign e_fwd_a = (ENABLE_FWD != 0)
        ? fwd_sel(ex_q.rs1, mem_q.reg_write, mem_q.rd, wb_q.reg_write, wb_q.rd)
        : 2'b00;
    assign e_fwd_b = (ENABLE_FWD != 0)
        ? fwd_sel(ex_q.rs2, mem_q.reg_write, mem_q.rd, wb_q.reg_write, wb_q.rd)
        : 2'b00;

    always_comb begin
        if (flush_e)      ex_d = '0;
        else if (stall_d) ex_d = ex_q;
        else              ex_d = dec;
        mem_d.reg_write  = ex_q.reg_write;
        mem_d.result_src = ex_q.result_src;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.rd         = ex_q.rd;
        wb_d.reg_write   = mem_q.reg_write;
        wb_d.result_src  = mem_q.result_src;
        wb_d.rd          = mem_q.rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign e_alu_control = ex_q.alu_ctrl;
    assign e_alu_src     = ex_q.alu_src;
    assign e_illegal     = ex_q.illegal;
    assign m_mem_write   = mem_q.mem_write;
    assign m_rd          = mem_q.rd;
    assign w_reg_write   = wb_q.reg_write;
    assign w_result_src  = wb_q.result_src;
    assign w_rd          = wb_q.rd;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: pipe_ctrl against an instruction-level pipeline model,
// for both the forwarding build (u0) and the stall-only build (u1).
`timescale 1ns/1ps
module tb_pipe_ctrl;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_BAD = 7'h7F;

    typedef struct packed {
        logic       vld;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       z;
        logic       lt;
        logic       ltu;
    } ins_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic [6:0] i_op  [2];
    logic [2:0] i_f3  [2];
    logic       i_f7  [2];
    logic [4:0] i_rs1 [2];
    logic [4:0] i_rs2 [2];
    logic [4:0] i_rd  [2];
    logic       i_z   [2];
    logic       i_lt  [2];
    logic       i_ltu [2];
    logic [2:0] o_imm [2];
    logic [3:0] o_alu [2];
    logic       o_asrc[2];
    logic [1:0] o_fa  [2];
    logic [1:0] o_fb  [2];
    logic [1:0] o_pcs [2];
    logic       o_ill [2];
    logic       o_sf  [2];
    logic       o_sd  [2];
    logic       o_fd  [2];
    logic       o_fe  [2];
    logic       o_mw  [2];
    logic [4:0] o_mrd [2];
    logic       o_rw  [2];
    logic [1:0] o_rsrc[2];
    logic [4:0] o_wrd [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_ctrl #(
            .ENABLE_FWD((g == 0) ? 1 : 0),
            .REG_AW(5),
            .ALUCTRL_W(4)
        ) u_dut (
            .clk(clk), .rst(rst[g]),
            .id_op(i_op[g]), .id_funct3(i_f3[g]), .id_funct7_5(i_f7[g]),
            .id_rs1(i_rs1[g]), .id_rs2(i_rs2[g]), .id_rd(i_rd[g]),
            .ex_zero(i_z[g]), .ex_lt(i_lt[g]), .ex_ltu(i_ltu[g]),
            .d_imm_src(o_imm[g]), .e_alu_control(o_alu[g]),
            .e_alu_src(o_asrc[g]), .e_fwd_a(o_fa[g]), .e_fwd_b(o_fb[g]),
            .e_pcsrc(o_pcs[g]), .e_illegal(o_ill[g]),
            .stall_f(o_sf[g]), .stall_d(o_sd[g]),
            .flush_d(o_fd[g]), .flush_e(o_fe[g]),
            .m_mem_write(o_mw[g]), .m_rd(o_mrd[g]),
            .w_reg_write(o_rw[g]), .w_result_src(o_rsrc[g]), .w_rd(o_wrd[g])
        );
    end

    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;
    int   build  = 0;
    ins_t prog[$];
    int   alu_tab[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    logic [6:0] op_tab[10] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR,
                               OP_JAL, OP_JR, OP_LUI, OP_AUI, OP_BAD};

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s build=%0d cycle=%0d got=%0d expected=%0d",
                      tag, build, cyc, got, exp);
    endtask

    function automatic ins_t mk(input logic [6:0] op, input int f3, input int f7,
                                input int rd, input int rs1, input int rs2);
        ins_t i;
        i = '0;
        i.vld = 1'b1;
        i.op  = op;
        i.f3  = 3'(f3);
        i.f7  = 1'(f7);
        i.rd  = 5'(rd);
        i.rs1 = 5'(rs1);
        i.rs2 = 5'(rs2);
        return i;
    endfunction

    function automatic ins_t rnd();
        ins_t i;
        i = mk(op_tab[$urandom_range(0, 9)], $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3));
        i.z   = 1'($urandom);
        i.lt  = 1'($urandom);
        i.ltu = 1'($urandom);
        return i;
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JR, OP_LUI, OP_AUI};
    endfunction

    function automatic bit wr(input ins_t i);
        return i.vld && (i.op inside {OP_R, OP_I, OP_LD, OP_JAL, OP_JR, OP_LUI, OP_AUI});
    endfunction

    function automatic int alu_of(input ins_t i);
        if (!i.vld) return 0;
        if (i.op == OP_R && i.f3 == 3'd0) return i.f7 ? 1 : 0;
        if ((i.op == OP_R || i.op == OP_I) && i.f3 == 3'd5) return i.f7 ? 9 : 8;
        if (i.op == OP_R || i.op == OP_I) return alu_tab[i.f3];
        if (i.op == OP_BR) return 1;
        if (i.op == OP_LUI) return 10;
        return 0;
    endfunction

    function automatic int imm_of(input logic [6:0] op);
        if (op == OP_ST) return 1;
        if (op == OP_BR) return 2;
        if (op == OP_JAL) return 3;
        if (op == OP_LUI || op == OP_AUI) return 4;
        return 0;
    endfunction

    function automatic bit taken(input ins_t i);
        if (!i.vld || i.op != OP_BR) return 0;
        case (i.f3)
            3'd0:    return i.z;
            3'd1:    return !i.z;
            3'd4:    return i.lt;
            3'd5:    return !i.lt;
            3'd6:    return i.ltu;
            3'd7:    return !i.ltu;
            default: return 0;
        endcase
    endfunction

    function automatic int pcs_of(input ins_t i);
        if (i.vld && i.op == OP_JR) return 2;
        if ((i.vld && i.op == OP_JAL) || taken(i)) return 1;
        return 0;
    endfunction

    function automatic int res_of(input ins_t i);
        if (!i.vld) return 0;
        if (i.op == OP_LD) return 1;
        if (i.op == OP_JAL || i.op == OP_JR) return 2;
        return 0;
    endfunction

    function automatic int rs_ex(input ins_t i, input bit b);
        if (!(i.vld && legal(i.op))) return 0;
        return b ? int'(i.rs2) : int'(i.rs1);
    endfunction

    function automatic int fwd_of(input int rs, input ins_t m, input ins_t w);
        if (wr(m) && m.rd != 0 && int'(m.rd) == rs) return 2;
        if (wr(w) && w.rd != 0 && int'(w.rd) == rs) return 1;
        return 0;
    endfunction

    function automatic bit hit(input ins_t s, input ins_t id);
        return wr(s) && s.rd != 0 && (s.rd == id.rs1 || s.rd == id.rs2);
    endfunction

    task automatic run(input int sel, input ins_t first, input int ncyc);
        ins_t idi, exi, mi, wi, nop;
        bit   r, fwd, haz, redir;
        int   pc;
        fwd   = (sel == 0);
        build = sel;
        nop   = mk(OP_I, 0, 0, 0, 0, 0);
        idi   = first;
        exi   = '0;
        mi    = '0;
        wi    = '0;
        for (int c = 0; c < ncyc; c++) begin
            cyc = c;
            r = (c < 2) || (prog.size() == 0 && $urandom_range(0, 39) == 0);
            rst[sel]   = r;
            i_op[sel]  = idi.op;
            i_f3[sel]  = idi.f3;
            i_f7[sel]  = idi.f7;
            i_rs1[sel] = idi.rs1;
            i_rs2[sel] = idi.rs2;
            i_rd[sel]  = idi.rd;
            i_z[sel]   = exi.z;
            i_lt[sel]  = exi.lt;
            i_ltu[sel] = exi.ltu;
            @(negedge clk);
            pc    = pcs_of(exi);
            redir = (pc != 0);
            if (fwd) haz = exi.vld && exi.op == OP_LD && hit(exi, idi);
            else     haz = hit(exi, idi) || hit(mi, idi);
            chk("d_imm_src", int'(o_imm[sel]), imm_of(idi.op));
            chk("e_alu_control", int'(o_alu[sel]), alu_of(exi));
            chk("e_alu_src", int'(o_asrc[sel]),
                int'(exi.vld && (exi.op inside {OP_I, OP_LD, OP_ST, OP_JR, OP_LUI, OP_AUI})));
            chk("e_fwd_a", int'(o_fa[sel]), fwd ? fwd_of(rs_ex(exi, 0), mi, wi) : 0);
            chk("e_fwd_b", int'(o_fb[sel]), fwd ? fwd_of(rs_ex(exi, 1), mi, wi) : 0);
            chk("e_pcsrc", int'(o_pcs[sel]), pc);
            chk("e_illegal", int'(o_ill[sel]), int'(exi.vld && !legal(exi.op)));
            chk("stall_f", int'(o_sf[sel]), int'(haz && !redir));
            chk("stall_d", int'(o_sd[sel]), int'(haz && !redir));
            chk("flush_d", int'(o_fd[sel]), int'(redir));
            chk("flush_e", int'(o_fe[sel]), int'(haz || redir));
            chk("m_mem_write", int'(o_mw[sel]), int'(mi.vld && mi.op == OP_ST));
            if (!mi.vld || wr(mi))
                chk("m_rd", int'(o_mrd[sel]), wr(mi) ? int'(mi.rd) : 0);
            chk("w_reg_write", int'(o_rw[sel]), int'(wr(wi)));
            chk("w_result_src", int'(o_rsrc[sel]), res_of(wi));
            if (!wi.vld || wr(wi))
                chk("w_rd", int'(o_wrd[sel]), wr(wi) ? int'(wi.rd) : 0);
            @(posedge clk);
            #1;
            if (r) begin
                exi = '0;
                mi  = '0;
                wi  = '0;
            end else begin
                wi = mi;
                mi = exi;
                if (redir) begin
                    exi = '0;
                    idi = nop;
                end else if (haz) begin
                    exi = '0;
                end else begin
                    exi = idi;
                    if (prog.size() > 0) idi = prog.pop_front();
                    else                 idi = rnd();
                end
            end
        end
        rst[sel] = 1'b1;
    endtask

    initial begin
        ins_t b;
        for (int g = 0; g < 2; g++) begin
            rst[g]   = 1'b1;
            i_op[g]  = OP_I;
            i_f3[g]  = '0;
            i_f7[g]  = 1'b0;
            i_rs1[g] = '0;
            i_rs2[g] = '0;
            i_rd[g]  = '0;
            i_z[g]   = 1'b0;
            i_lt[g]  = 1'b0;
            i_ltu[g] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        prog.push_back(mk(OP_R, 0, 1, 6, 5, 3));
        prog.push_back(mk(OP_R, 6, 0, 7, 5, 0));
        prog.push_back(mk(OP_LD, 2, 0, 4, 1, 0));
        prog.push_back(mk(OP_R, 0, 0, 8, 4, 4));
        prog.push_back(mk(OP_I, 0, 0, 0, 0, 0));
        b = mk(OP_BR, 6, 0, 0, 1, 2); b.ltu = 1'b1;
        prog.push_back(b);
        prog.push_back(mk(OP_I, 0, 0, 10, 0, 0));
        b = mk(OP_BR, 5, 0, 0, 1, 2); b.lt = 1'b1;
        prog.push_back(b);
        b = mk(OP_BR, 2, 0, 0, 1, 2); b.z = 1'b1; b.lt = 1'b1; b.ltu = 1'b1;
        prog.push_back(b);
        prog.push_back(mk(OP_JAL, 0, 0, 1, 0, 0));
        prog.push_back(mk(OP_I, 0, 0, 11, 0, 0));
        prog.push_back(mk(OP_JR, 0, 0, 0, 1, 0));
        prog.push_back(mk(OP_I, 0, 0, 12, 0, 0));
        run(0, mk(OP_R, 0, 0, 5, 1, 2), 400);

        prog.delete();
        prog.push_back(mk(OP_R, 0, 0, 9, 3, 3));
        prog.push_back(mk(OP_BAD, 0, 0, 5, 0, 0));
        prog.push_back(mk(OP_I, 0, 0, 3, 0, 0));
        prog.push_back(mk(OP_JR, 0, 0, 1, 2, 0));
        prog.push_back(mk(OP_R, 0, 0, 9, 3, 1));
        prog.push_back(mk(OP_I, 0, 0, 0, 0, 0));
        run(1, mk(OP_I, 0, 0, 3, 0, 0), 400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
